// File: rtl/nominal_plant_model_pkg.sv
// Shared types and constants for the nominal plant model (sfix32_En10 datapath).
// Latency: n/a (package).
// Backpressure: n/a (package).
package nominal_plant_model_pkg;

    localparam int FRAC_BITS = 10;
    localparam int DT_SHIFT  = 10;
    localparam int ACC_SHIFT = 1;

    localparam logic signed [31:0] SFIX32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SFIX32_MIN = 32'sh8000_0000;

    // Two guard bits are enough for any add/sub of two sign-extended 32-bit values
    typedef logic signed [33:0] sfix34_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VEL,
        ST_POS,
        ST_ERR,
        ST_DONE
    } state_t;

    function automatic sfix34_t sext34(input logic signed [31:0] x);
        return {{2{x[31]}}, x};
    endfunction

endpackage

// File: rtl/nominal_plant_model_sat_add34.sv
// 34-bit signed add/subtract with saturation back to the sfix32 range.
// Latency: combinational.
// Backpressure: none.
module nominal_plant_model_sat_add34
    import nominal_plant_model_pkg::*;
(
    input  sfix34_t            a,
    input  sfix34_t            b,
    input  logic               sub,
    output logic signed [31:0] y
);

    sfix34_t sum;

    // Top three bits disagree exactly when the result does not fit in 32 bits
    always_comb begin
        sum = sub ? (a - b) : (a + b);
        if (sum[33:31] == 3'b000 || sum[33:31] == 3'b111) begin
            y = sum[31:0];
        end else if (sum[33]) begin
            y = SFIX32_MIN;
        end else begin
            y = SFIX32_MAX;
        end
    end

endmodule

// File: rtl/nominal_plant_model.sv
// Nominal plant theta_dd = 2*u, semi-implicit Euler step per sample_tick, returns e / e_dot.
// Latency: tick in cycle N -> valid in cycle N+4; busy N+1..N+4; next tick accepted at N+5.
// Backpressure: none; ticks while busy are dropped and flagged by sticky overrun.
module nominal_plant_model
    import nominal_plant_model_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               init_load,
    input  logic signed [31:0] init_theta,
    input  logic signed [31:0] init_theta_dot,
    input  logic signed [31:0] u_t,
    input  logic signed [31:0] theta_d,
    input  logic signed [31:0] theta_d_dot,
    output logic signed [31:0] theta_m,
    output logic signed [31:0] theta_dot_m,
    output logic signed [31:0] e,
    output logic signed [31:0] e_dot,
    output logic               valid,
    output logic               busy,
    output logic               overrun
);

    // Each state names the phase whose result has just been written. The adder
    // therefore always works one phase ahead: the velocity update happens on the
    // accepting edge (u_t is live then), so by DONE every output is settled and
    // valid can be asserted while the new values are visible.
    state_t             state, state_nxt;
    logic signed [31:0] theta_d_cap, theta_d_dot_cap;
    sfix34_t            add_a, add_b;
    logic               add_sub;
    logic signed [31:0] add_y;
    logic               accept;

    assign accept = sample_tick && !init_load && (state == ST_IDLE);
    assign busy   = (state != ST_IDLE);
    assign valid  = (state == ST_DONE);

    nominal_plant_model_sat_add34 u_add (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .y   (add_y)
    );

    // Operand mux for the single shared adder
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            ST_IDLE: begin
                add_a = sext34(theta_dot_m);
                add_b = (sext34(u_t) <<< ACC_SHIFT) >>> DT_SHIFT;
            end
            ST_VEL: begin
                add_a = sext34(theta_m);
                add_b = sext34(theta_dot_m) >>> DT_SHIFT;
            end
            ST_POS: begin
                add_a   = sext34(theta_m);
                add_b   = sext34(theta_d_cap);
                add_sub = 1'b1;
            end
            ST_ERR: begin
                add_a   = sext34(theta_dot_m);
                add_b   = sext34(theta_d_dot_cap);
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    // Step sequencing; init_load aborts any step in progress
    always_comb begin
        state_nxt = state;
        if (init_load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (sample_tick) state_nxt = ST_VEL;
                ST_VEL:  state_nxt = ST_POS;
                ST_POS:  state_nxt = ST_ERR;
                ST_ERR:  state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: load, then one adder result written per phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta_m         <= '0;
            theta_dot_m     <= '0;
            e               <= '0;
            e_dot           <= '0;
            theta_d_cap     <= '0;
            theta_d_dot_cap <= '0;
        end else if (init_load) begin
            theta_m     <= init_theta;
            theta_dot_m <= init_theta_dot;
            e           <= '0;
            e_dot       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        theta_dot_m     <= add_y;
                        theta_d_cap     <= theta_d;
                        theta_d_dot_cap <= theta_d_dot;
                    end
                end
                ST_VEL:  theta_m <= add_y;
                ST_POS:  e       <= add_y;
                ST_ERR:  e_dot   <= add_y;
                default: ;
            endcase
        end
    end

    // Sticky flag for ticks that arrive while a step is still running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (init_load) begin
            overrun <= 1'b0;
        end else if (sample_tick && busy) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nominal_plant_model.sv
module tb_nominal_plant_model;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic               init_load = 1'b0;
    logic signed [31:0] init_theta = '0;
    logic signed [31:0] init_theta_dot = '0;
    logic signed [31:0] u_t = '0;
    logic signed [31:0] theta_d = '0;
    logic signed [31:0] theta_d_dot = '0;
    logic signed [31:0] theta_m, theta_dot_m, e, e_dot;
    logic               valid, busy, overrun;

    int tests = 0;
    int fails = 0;

    // Reference state in plain integers
    longint m_th = 0, m_thd = 0, m_e = 0, m_edot = 0;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    always #5 clk = ~clk;

    nominal_plant_model dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .init_load      (init_load),
        .init_theta     (init_theta),
        .init_theta_dot (init_theta_dot),
        .u_t            (u_t),
        .theta_d        (theta_d),
        .theta_d_dot    (theta_d_dot),
        .theta_m        (theta_m),
        .theta_dot_m    (theta_dot_m),
        .e              (e),
        .e_dot          (e_dot),
        .valid          (valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    function automatic longint sat32(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    // Division rounding toward minus infinity (d > 0)
    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_step(input longint u, input longint td, input longint tdd);
        m_thd  = sat32(m_thd + fdiv(2 * u, 1024));
        m_th   = sat32(m_th + fdiv(m_thd, 1024));
        m_e    = sat32(m_th - td);
        m_edot = sat32(m_thd - tdd);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, " theta_m"}, longint'(theta_m), m_th);
        chk({name, " theta_dot_m"}, longint'(theta_dot_m), m_thd);
        chk({name, " e"}, longint'(e), m_e);
        chk({name, " e_dot"}, longint'(e_dot), m_edot);
    endtask

    task automatic do_load(input longint th, input longint thd);
        @(negedge clk);
        init_load      = 1'b1;
        init_theta     = 32'(th);
        init_theta_dot = 32'(thd);
        @(negedge clk);
        init_load = 1'b0;
        m_th = th; m_thd = thd; m_e = 0; m_edot = 0;
    endtask

    // One full step: checks latency, busy width and model results
    task automatic run_step(input string name, input longint u, input longint td, input longint tdd);
        int k;
        int nbusy;
        @(negedge clk);
        sample_tick = 1'b1;
        u_t = 32'(u); theta_d = 32'(td); theta_d_dot = 32'(tdd);
        @(negedge clk);
        sample_tick = 1'b0;
        u_t = 32'($urandom); theta_d = 32'($urandom); theta_d_dot = 32'($urandom);
        k = 1;
        nbusy = 0;
        while (!valid && k < 10) begin
            if (busy) nbusy++;
            @(negedge clk);
            k++;
        end
        if (busy) nbusy++;
        model_step(u, td, tdd);
        chk({name, " latency"}, k, 4);
        chk({name, " busy cycles"}, nbusy, 4);
        chk_model(name);
        @(negedge clk);
        chk({name, " busy drop"}, longint'(busy), 0);
    endtask

    typedef struct {
        longint ith, ithd, u, td, tdd;
        longint x_th, x_thd, x_e, x_edot;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nvalid;

        vecs[0] = '{0, 0, 0, 0, 0,                 0, 0, 0, 0};
        vecs[1] = '{0, 1048576, 0, 512, 0,         1024, 1048576, 512, 1048576};
        vecs[2] = '{32'sh7FFFFF00, MAXV, 1024, 0, 0, MAXV, MAXV, MAXV, MAXV};
        vecs[3] = '{0, 0, -1, 0, 5,                -1, -1, -1, -6};
        vecs[4] = '{MINV, MINV, -1024, 1, 1,       MINV, MINV, MINV, MINV};
        vecs[5] = '{MAXV, 0, 0, -5, 0,             MAXV, 0, MAXV, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset theta_m", longint'(theta_m), 0);
        chk("reset theta_dot_m", longint'(theta_dot_m), 0);
        chk("reset e", longint'(e), 0);
        chk("reset e_dot", longint'(e_dot), 0);
        chk("reset valid", longint'(valid), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset overrun", longint'(overrun), 0);
        rst_n = 1'b1;

        run_step("first zero step", 0, 0, 0);

        // Table of single steps from a loaded state, with hand-derived results
        for (int i = 0; i < 6; i++) begin
            do_load(vecs[i].ith, vecs[i].ithd);
            run_step($sformatf("vec%0d", i), vecs[i].u, vecs[i].td, vecs[i].tdd);
            chk($sformatf("vec%0d const theta_m", i), longint'(theta_m), vecs[i].x_th);
            chk($sformatf("vec%0d const theta_dot_m", i), longint'(theta_dot_m), vecs[i].x_thd);
            chk($sformatf("vec%0d const e", i), longint'(e), vecs[i].x_e);
            chk($sformatf("vec%0d const e_dot", i), longint'(e_dot), vecs[i].x_edot);
        end

        // Constant acceleration: velocity ramps 2,4,6 while position stays 0
        do_load(0, 0);
        for (int i = 1; i <= 3; i++) begin
            run_step($sformatf("ramp%0d", i), 1024, 0, 0);
            chk($sformatf("ramp%0d vel", i), longint'(theta_dot_m), 2 * i);
            chk($sformatf("ramp%0d pos", i), longint'(theta_m), 0);
        end

        // Tick two cycles into a busy step: ignored, overrun sticks
        do_load(100, 3000);
        @(negedge clk);
        sample_tick = 1'b1; u_t = 2048; theta_d = 7; theta_d_dot = 9;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1; u_t = 32'sh4000_0000;
        @(negedge clk);
        sample_tick = 1'b0;
        chk("overrun set", longint'(overrun), 1);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid) nvalid++;
            @(negedge clk);
        end
        model_step(2048, 7, 9);
        chk("overrun valid count", nvalid, 1);
        chk_model("overrun step");
        run_step("after overrun", 0, 0, 0);
        chk("overrun sticky", longint'(overrun), 1);

        // init_load together with tick: load wins, no valid, overrun cleared
        @(negedge clk);
        init_load = 1'b1; sample_tick = 1'b1;
        init_theta = -4096; init_theta_dot = 777; u_t = 1024;
        @(negedge clk);
        init_load = 1'b0; sample_tick = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid || busy) nvalid++;
            @(negedge clk);
        end
        chk("load+tick no activity", nvalid, 0);
        chk("load+tick overrun", longint'(overrun), 0);
        chk("load+tick theta_m", longint'(theta_m), -4096);
        chk("load+tick theta_dot_m", longint'(theta_dot_m), 777);
        chk("load+tick e", longint'(e), 0);
        chk("load+tick e_dot", longint'(e_dot), 0);
        m_th = -4096; m_thd = 777; m_e = 0; m_edot = 0;

        // Reset in the middle of a step aborts it
        @(negedge clk);
        sample_tick = 1'b1; u_t = 5000;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid) nvalid++;
            @(negedge clk);
        end
        chk("midreset no valid", nvalid, 0);
        m_th = 0; m_thd = 0; m_e = 0; m_edot = 0;
        chk_model("midreset");

        // Randomized steps against the reference
        for (int i = 0; i < 40; i++) begin
            longint u, td, tdd;
            if (i % 10 == 0)
                do_load(longint'(int'($urandom)), longint'(int'($urandom)) / 4);
            if (i % 7 == 3) u = longint'(int'($urandom));
            else u = longint'($urandom_range(0, 200000)) - 100000;
            td  = longint'(int'($urandom));
            tdd = longint'(int'($urandom));
            run_step($sformatf("rand%0d", i), u, td, tdd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
